fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Two-wide instruction fetch stage. Directly upstream of the branch predictor / rollback arbiter, and consumes its redirect outputs.
- Holds the architectural fetch PC and drives the instruction-cache address.
- Latches one fetched group (up to 2 instructions) per cycle into an output register. The branch predictor examines that register combinationally, then dispatch consumes it.
- Applies rollback and predicted-taken redirects with a 1-cycle bubble, and keeps fetch performance counters.

Parameters:
NUM_SUPER, 2, fetch width; only 2 is supported
RESET_PC, 64'h0, PC loaded on reset
NOOP_INST, 32'h47ff041f, IR value driven in invalid slots

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
proc2Icache_addr  out  64  fetch line address: {PC_reg[63:3],3'b000}
Icache_data_out  in  64  line data; [31:0] is the word at addr, [63:32] is the word at addr+4
Icache_valid_out  in  1  same-cycle hit; low means miss
dispatch_stall  in  1  dispatch cannot accept the output group this cycle
bp_rollback_en  in  1  rollback request (mispredict or load violation)
bp_take_branch  in  2  per-slot predicted-taken for the group in the output register
bp_target  in  64  redirect PC (rollback target or predicted target)
if_NPC_out  out  2x64  per-slot PC+4
if_IR_out  out  2x32  per-slot instruction
if_valid_out  out  2  per-slot valid
if_PC_reg  out  64  current fetch PC (debug)
perf_fetched  out  64  count of valid instructions accepted by dispatch
perf_bubbles  out  64  cycles where dispatch was free but the output group was fully invalid

Behaviour:
- Reset (synchronous, highest priority):
  - PC_reg=RESET_PC.
  - if_valid_out=2'b00, if_IR_out=NOOP_INST, if_NPC_out=0.
  - Both counters=0.
- Group formation from PC_reg:
  - slot0 = word selected by PC_reg[2] (0 selects [31:0], 1 selects [63:32]); NPC0=PC_reg+4.
  - slot1 = Icache_data_out[63:32] only when PC_reg[2]==0; NPC1=PC_reg+8.
  - If PC_reg[2]==1, slot1 is invalid, with IR=NOOP_INST and NPC1=PC_reg+8.
  - seq_PC = PC_reg + (PC_reg[2] ? 4 : 8). Arithmetic is 64-bit and wraps mod 2^64.
- "consume" = !dispatch_stall. "redirect_pred" = consume && |bp_take_branch && !bp_rollback_en.
- Per-cycle priority:
  1. bp_rollback_en: PC_reg<=bp_target; output register <= invalid group; this overrides dispatch_stall. The fetched line is discarded.
  2. redirect_pred: PC_reg<=bp_target; output register <= invalid group. The current fetch is discarded (wrong path).
  3. dispatch_stall (and no rollback): PC_reg and output register hold. A predicted-taken on the held group is ignored until consume.
  4. consume && !Icache_valid_out: PC_reg holds (retry); output register <= invalid group.
  5. consume && Icache_valid_out: output register <= formed group with valid bits set per the rules above; PC_reg<=seq_PC.
- Latency: the instruction at PC_reg appears on if_*_out the cycle after a hit. A redirect costs exactly 1 bubble cycle.
- The BP-side mask of slot1 after a taken slot0 is not applied here. The raw valid bits are presented.
- Counters update only when consume && !bp_rollback_en:
  - perf_fetched += popcount(if_valid_out).
  - perf_bubbles += 1 if if_valid_out==0.
  - Counters saturate at all-ones.
- Reset asserted mid-miss or mid-stall: all state returns to reset values next edge; no pending request survives.
- bp_target is used as given; bits [1:0] are ignored (forced 0 into PC_reg).

Test Plan:
1. Reset, then continuous hits, no stall:
   - proc2Icache_addr = 0x0, 0x8, 0x10.
   - if_valid_out=2'b11 from cycle 1 onward.
   - if_NPC_out = {0x8,0x4}, then {0x10,0xC}.
   - perf_fetched=6 after 3 groups.
2. Odd-word redirect: rollback with bp_target=0x104.
   - Next group has slot0 = word [63:32] of line 0x100, NPC0=0x108; if_valid_out=2'b01.
   - The following fetch address is 0x108.
3. Predicted-taken during stall:
   - bp_take_branch=2'b01, bp_target=0x200, dispatch_stall=1 for 3 cycles: PC_reg and outputs hold.
   - Stall drops: output goes invalid and PC_reg=0x200; group from 0x200 is valid one cycle later.
4. Rollback during stall: dispatch_stall=1 and bp_rollback_en=1, target 0x400.
   - Next cycle if_valid_out=0 and PC_reg=0x400, regardless of stall.
5. Icache miss for 4 cycles at 0x40:
   - proc2Icache_addr stays 0x40; if_valid_out=0; perf_bubbles +4.
   - On hit, the group from 0x40 appears next cycle.
6. Reset asserted while missing at PC 0x80: next edge PC_reg=RESET_PC, outputs invalid, counters=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: two-wide instruction fetch stage.
//
// Holds the architectural fetch PC and drives the I-cache line address.
// Each cycle it forms a group of up to two instructions from the returned
// line and registers it for the branch predictor and dispatch. Rollback and
// predicted-taken redirects load a new PC and insert one bubble. Two
// saturating performance counters track accepted instructions and bubbles.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   proc2Icache_addr    8-byte aligned line address of the fetch PC
//   Icache_data_out     line data: [31:0] at addr, [63:32] at addr+4
//   Icache_valid_out    same-cycle hit (low = miss, retry)
//   dispatch_stall      dispatch cannot take the output group this cycle
//   bp_rollback_en      rollback redirect (overrides stall)
//   bp_take_branch      per-slot predicted-taken for the output group
//   bp_target           redirect PC; bits [1:0] are ignored
//   if_NPC_out          per-slot PC+4
//   if_IR_out           per-slot instruction (NOOP_INST when invalid)
//   if_valid_out        per-slot valid
//   if_PC_reg           current fetch PC
//   perf_fetched        valid instructions accepted by dispatch
//   perf_bubbles        free dispatch cycles with a fully invalid group
module fetch_stage #(
    parameter int          NUM_SUPER = 2,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOOP_INST = 32'h47ff041f
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [63:0]                proc2Icache_addr,
    input  logic [63:0]                Icache_data_out,
    input  logic                       Icache_valid_out,
    input  logic                       dispatch_stall,
    input  logic                       bp_rollback_en,
    input  logic [NUM_SUPER-1:0]       bp_take_branch,
    input  logic [63:0]                bp_target,
    output logic [NUM_SUPER-1:0][63:0] if_NPC_out,
    output logic [NUM_SUPER-1:0][31:0] if_IR_out,
    output logic [NUM_SUPER-1:0]       if_valid_out,
    output logic [63:0]                if_PC_reg,
    output logic [63:0]                perf_fetched,
    output logic [63:0]                perf_bubbles
);

    logic [63:0] pc_reg;
    logic        consume;
    logic        redirect_pred;
    logic        redirect;
    logic        count_en;
    logic [63:0] redirect_pc;
    logic        unused_tgt_bits;

    logic [1:0][31:0] grp_ir;
    logic [1:0][63:0] grp_npc;
    logic [1:0]       grp_valid;
    logic [63:0]      seq_pc;

    logic [63:0] fetched_inc;
    logic [64:0] fetched_sum;
    logic [64:0] bubbles_sum;
    logic [63:0] fetched_next;
    logic [63:0] bubbles_next;

    assign proc2Icache_addr = {pc_reg[63:3], 3'b000};
    assign if_PC_reg        = pc_reg;

    assign consume         = !dispatch_stall;
    assign redirect_pred   = consume && (|bp_take_branch) && !bp_rollback_en;
    assign redirect        = bp_rollback_en || redirect_pred;
    assign count_en        = consume && !bp_rollback_en;
    assign redirect_pc     = {bp_target[63:2], 2'b00};
    assign unused_tgt_bits = ^bp_target[1:0];

    // An odd-word PC only has one instruction left in the line, so slot1
    // is invalid and the next sequential PC is the following line.
    always_comb begin
        grp_npc[0] = pc_reg + 64'd4;
        grp_npc[1] = pc_reg + 64'd8;
        if (pc_reg[2]) begin
            grp_ir[0] = Icache_data_out[63:32];
            grp_ir[1] = NOOP_INST;
            grp_valid = 2'b01;
            seq_pc    = pc_reg + 64'd4;
        end else begin
            grp_ir[0] = Icache_data_out[31:0];
            grp_ir[1] = Icache_data_out[63:32];
            grp_valid = 2'b11;
            seq_pc    = pc_reg + 64'd8;
        end
    end

    // Counters saturate: a carry out of the 64-bit sum pins them at all-ones.
    always_comb begin
        fetched_inc  = 64'(if_valid_out[0]) + 64'(if_valid_out[1]);
        fetched_sum  = {1'b0, perf_fetched} + {1'b0, fetched_inc};
        bubbles_sum  = {1'b0, perf_bubbles} + 65'((if_valid_out == '0) ? 1 : 0);
        fetched_next = fetched_sum[64] ? '1 : fetched_sum[63:0];
        bubbles_next = bubbles_sum[64] ? '1 : bubbles_sum[63:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            if_valid_out <= '0;
            if_IR_out    <= {NOOP_INST, NOOP_INST};
            if_NPC_out   <= '0;
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (count_en) begin
                perf_fetched <= fetched_next;
                perf_bubbles <= bubbles_next;
            end
            if (redirect) begin
                // The line fetched this cycle is on the wrong path.
                pc_reg       <= redirect_pc;
                if_valid_out <= '0;
                if_IR_out    <= {NOOP_INST, NOOP_INST};
                if_NPC_out   <= '0;
            end else if (dispatch_stall) begin
                // Hold PC and output group; a taken prediction waits for consume.
            end else if (!Icache_valid_out) begin
                if_valid_out <= '0;
                if_IR_out    <= {NOOP_INST, NOOP_INST};
                if_NPC_out   <= '0;
            end else begin
                pc_reg       <= seq_pc;
                if_valid_out <= grp_valid;
                if_IR_out    <= grp_ir;
                if_NPC_out   <= grp_npc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOOP = 32'h47ff041f;

    logic             clock;
    logic             reset;
    logic [63:0]      proc2Icache_addr;
    logic [63:0]      Icache_data_out;
    logic             Icache_valid_out;
    logic             dispatch_stall;
    logic             bp_rollback_en;
    logic [1:0]       bp_take_branch;
    logic [63:0]      bp_target;
    logic [1:0][63:0] if_NPC_out;
    logic [1:0][31:0] if_IR_out;
    logic [1:0]       if_valid_out;
    logic [63:0]      if_PC_reg;
    logic [63:0]      perf_fetched;
    logic [63:0]      perf_bubbles;

    fetch_stage dut (
        .clock            (clock),
        .reset            (reset),
        .proc2Icache_addr (proc2Icache_addr),
        .Icache_data_out  (Icache_data_out),
        .Icache_valid_out (Icache_valid_out),
        .dispatch_stall   (dispatch_stall),
        .bp_rollback_en   (bp_rollback_en),
        .bp_take_branch   (bp_take_branch),
        .bp_target        (bp_target),
        .if_NPC_out       (if_NPC_out),
        .if_IR_out        (if_IR_out),
        .if_valid_out     (if_valid_out),
        .if_PC_reg        (if_PC_reg),
        .perf_fetched     (perf_fetched),
        .perf_bubbles     (perf_bubbles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction memory contents: a scrambled function of the byte address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579bdf;
    endfunction

    always_comb begin
        Icache_data_out = {mem_word(proc2Icache_addr + 64'd4), mem_word(proc2Icache_addr)};
    end

    typedef struct {
        logic [63:0]      pc;
        logic [1:0]       valid;
        logic [1:0][31:0] ir;
        logic [1:0][63:0] npc;
        logic             chk_npc;
        logic [63:0]      fetched;
        logic [63:0]      bubbles;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: what the stage should hold after each edge.
    logic [63:0]      m_pc;
    logic [1:0]       m_valid;
    logic [1:0][31:0] m_ir;
    logic [1:0][63:0] m_npc;
    logic             m_chk_npc;
    logic [63:0]      m_fet;
    logic [63:0]      m_bub;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
        return (a > ~b) ? '1 : a + b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue the
    // state expected right after the coming rising edge.
    task automatic step(input logic rst, input logic stall, input logic rb,
                        input logic [1:0] take, input logic [63:0] tgt, input logic hit);
        exp_t e;
        int   n;
        reset            = rst;
        dispatch_stall   = stall;
        bp_rollback_en   = rb;
        bp_take_branch   = take;
        bp_target        = tgt;
        Icache_valid_out = hit;
        if (rst) begin
            m_pc = 64'h0; m_valid = 2'b00; m_ir = {NOOP, NOOP};
            m_npc = '0; m_chk_npc = 1'b1; m_fet = '0; m_bub = '0;
        end else begin
            if (!stall && !rb) begin
                m_fet = sat_add(m_fet, 64'($countones(m_valid)));
                m_bub = sat_add(m_bub, (m_valid == 2'b00) ? 64'd1 : 64'd0);
            end
            if (rb || (!stall && take != 2'b00)) begin
                m_pc = tgt & ~64'd3;
                m_valid = 2'b00; m_ir = {NOOP, NOOP}; m_chk_npc = 1'b0;
            end else if (stall) begin
                // nothing moves
            end else if (!hit) begin
                m_valid = 2'b00; m_ir = {NOOP, NOOP}; m_chk_npc = 1'b0;
            end else begin
                // instructions remaining in the current 8-byte line
                n = (8 - int'(m_pc[2:0])) / 4;
                for (int k = 0; k < 2; k++) begin
                    m_valid[k] = (k < n);
                    m_ir[k]    = (k < n) ? mem_word(m_pc + 64'(4 * k)) : NOOP;
                    m_npc[k]   = m_pc + 64'(4 * k + 4);
                end
                m_chk_npc = 1'b1;
                m_pc = m_pc + 64'(4 * n);
            end
        end
        e.pc = m_pc; e.valid = m_valid; e.ir = m_ir; e.npc = m_npc;
        e.chk_npc = m_chk_npc; e.fetched = m_fet; e.bubbles = m_bub;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_reg", if_PC_reg, e.pc);
                chk("icache_addr", proc2Icache_addr, {e.pc[63:3], 3'b000});
                chk("valid", 64'(if_valid_out), 64'(e.valid));
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("ir%0d", k), 64'(if_IR_out[k]), 64'(e.ir[k]));
                    if (e.chk_npc)
                        chk($sformatf("npc%0d", k), if_NPC_out[k], e.npc[k]);
                end
                chk("perf_fetched", perf_fetched, e.fetched);
                chk("perf_bubbles", perf_bubbles, e.bubbles);
            end
        end
    end

    initial begin : stimulus
        logic rst_r, stall_r, rb_r, hit_r;
        logic [1:0] take_r;
        logic [63:0] tgt_r;

        reset = 1'b1; dispatch_stall = 1'b0; bp_rollback_en = 1'b0;
        bp_take_branch = 2'b00; bp_target = '0; Icache_valid_out = 1'b0;

        step(1, 0, 0, 2'b00, 64'h0, 0);
        step(1, 0, 0, 2'b00, 64'h0, 0);

        // continuous hits from reset
        repeat (4) step(0, 0, 0, 2'b00, 64'h0, 1);

        // rollback to an odd word, then sequential
        step(0, 0, 1, 2'b00, 64'h104, 1);
        repeat (3) step(0, 0, 0, 2'b00, 64'h0, 1);

        // predicted-taken held under stall, taken once stall drops
        repeat (3) step(0, 1, 0, 2'b01, 64'h200, 1);
        step(0, 0, 0, 2'b01, 64'h200, 1);
        repeat (2) step(0, 0, 0, 2'b00, 64'h0, 1);

        // rollback during stall; low target bits dropped
        step(0, 1, 1, 2'b00, 64'h403, 1);
        repeat (2) step(0, 0, 0, 2'b00, 64'h0, 1);

        // four misses at 0x40, then hit
        step(0, 0, 1, 2'b00, 64'h40, 1);
        repeat (4) step(0, 0, 0, 2'b00, 64'h0, 0);
        repeat (2) step(0, 0, 0, 2'b00, 64'h0, 1);

        // wrap past the top of the address space
        step(0, 0, 1, 2'b00, 64'hFFFF_FFFF_FFFF_FFF8, 1);
        repeat (3) step(0, 0, 0, 2'b00, 64'h0, 1);

        // reset while missing at 0x80
        step(0, 0, 1, 2'b00, 64'h80, 1);
        repeat (2) step(0, 0, 0, 2'b00, 64'h0, 0);
        step(1, 0, 0, 2'b00, 64'h0, 0);
        repeat (2) step(0, 0, 0, 2'b00, 64'h0, 1);

        repeat (500) begin
            rst_r   = ($urandom_range(0, 49) == 0);
            stall_r = ($urandom_range(0, 3) == 0);
            rb_r    = ($urandom_range(0, 9) == 0);
            take_r  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tgt_r   = {$urandom, $urandom};
            hit_r   = ($urandom_range(0, 3) != 0);
            step(rst_r, stall_r, rb_r, take_r, tgt_r, hit_r);
        end
        step(0, 0, 0, 2'b00, 64'h0, 1);

        repeat (3) @(posedge clock);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
